sp_ram_arb: RTL and testbench
=============================

SP_RAM_ARB -- requirements
Module: sp_ram_arb

Interface
REQ-001 Parameter RAM_SIZE, default 32768: memory size in bytes; SHALL be a power of two.
REQ-002 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-003 Parameter NUM_PORTS, default 2: requester count, legal range 1..4.
REQ-004 Parameter OUT_REG, default 0: 1 adds an output register stage.
REQ-005 Parameter CLEAR_ON_RESET, default 1: 1 zero-fills the array after reset.
REQ-006 Derived constants: ADDR_WIDTH = $clog2(RAM_SIZE); BE_W = DATA_WIDTH/8; DEPTH = RAM_SIZE/BE_W words.
REQ-007 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-008 rst_i  in  1  synchronous, active-high reset.
REQ-009 req_i  in  NUM_PORTS  per-port access request.
REQ-010 we_i  in  NUM_PORTS  per-port write (1) / read (0).
REQ-011 addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port byte address.
REQ-012 be_i  in  NUM_PORTS*BE_W  per-port byte enables, writes only.
REQ-013 wdata_i  in  NUM_PORTS*DATA_WIDTH  per-port write data.
REQ-014 gnt_o  out  NUM_PORTS  per-port grant, combinational, one-hot or zero.
REQ-015 rvalid_o  out  NUM_PORTS  per-port read-data-valid pulse.
REQ-016 rdata_o  out  NUM_PORTS*DATA_WIDTH  per-port read data.
REQ-017 busy_o  out  1  high while the clear sequence runs.

Function
REQ-018 Word index SHALL be addr[ADDR_WIDTH-1:$clog2(BE_W)]; low address bits are ignored.
REQ-019 At most one array access SHALL occur per cycle.
REQ-020 FSM states: CLEAR, RUN. Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-021 CLEAR: writes zero to word 0..DEPTH-1, one word per cycle, with busy_o=1 and gnt_o=0; after word DEPTH-1, go to RUN (busy_o=0 from the next cycle).
REQ-022 RUN: gnt_o SHALL grant exactly one requesting port whenever any req_i bit is high.
REQ-023 Arbitration SHALL be round-robin: search starts at (last granted port + 1) mod NUM_PORTS; after reset, port 0 has highest priority.
REQ-024 The round-robin pointer SHALL update only on a cycle with a grant.
REQ-025 A requester SHALL hold req/we/addr/be/wdata stable until granted; the access executes in the grant cycle.
REQ-026 Granted write: update only bytes with be=1 at the clock edge ending the grant cycle; no rvalid.
REQ-027 Granted read: rvalid_o[p] pulses for one cycle exactly 1+OUT_REG cycles after the grant cycle, with rdata_o[p] valid in that cycle.
REQ-028 rdata_o[p] SHALL hold its last returned value until the next read response for port p.
REQ-029 A read granted in the cycle after a write to the same word SHALL return the newly written data.
REQ-030 Back-to-back reads (any ports) SHALL be fully pipelined, one response per cycle.
REQ-031 With a single requester holding req_i high, that requester SHALL be granted every cycle.

Reset
REQ-032 rst_i SHALL set gnt_o=0, rvalid_o=0, rdata_o=0, RR pointer to port 0, clear counter to 0, and busy_o=CLEAR_ON_RESET on the cycle after it is sampled.
REQ-033 rst_i during CLEAR SHALL restart clearing at word 0.
REQ-034 rst_i with reads in flight SHALL flush the pipeline; no rvalid for those reads.
REQ-035 Array contents are not reset when CLEAR_ON_RESET=0.

Verification
REQ-036 Reset with CLEAR_ON_RESET=1, DEPTH=8192 -> busy_o high for exactly 8192 cycles; a read of word 100 afterwards returns 0x00000000.
REQ-037 Port 0 writes 0xDEADBEEF to addr 0x40 with be=4'b1111, then writes 0x000000AA with be=4'b0001; a following read -> 0xDEADBEAA at 1+OUT_REG cycles after grant.
REQ-038 Ports 0 and 1 both request continuously -> grants alternate 0,1,0,1 starting with port 0 after reset.
REQ-039 Write 0x12345678 to 0x80, then a read of 0x80 on the next cycle from another port -> 0x12345678 returned.
REQ-040 Three reads issued in consecutive cycles with OUT_REG=1, then rst_i -> no rvalid_o pulse follows the reset.
REQ-041 Assert rst_i at clear word 500 -> clearing restarts at word 0; busy_o stays high for a further DEPTH cycles.

Source files
------------

// File: rtl/sp_ram_arb_if.sv
// sp_ram_arb_if: request/response bundle for the arbitrated single-port RAM.
//   All per-port fields are flat vectors, port p occupying slice p.
//   master : requester side (drives req/we/addr/be/wdata, sees gnt/rvalid/rdata)
//   slave  : RAM side (the sp_ram_arb module)
interface sp_ram_arb_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]            req_i;
    logic [NUM_PORTS-1:0]            we_i;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_PORTS*BE_W-1:0]       be_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_PORTS-1:0]            gnt_o;
    logic [NUM_PORTS-1:0]            rvalid_o;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o;

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/sp_ram_arb.sv
// sp_ram_arb: single-port RAM shared by NUM_PORTS requesters through a
// round-robin arbiter, with an optional zero-fill sequence after reset.
//   clk    : rising-edge clock
//   rst_i  : synchronous active-high reset
//   bus    : sp_ram_arb_if slave (per-port req/we/addr/be/wdata in,
//            combinational gnt, rvalid pulse and held rdata out)
//   busy_o : high while the array is being zero-filled
// Read latency is 1+OUT_REG cycles after the grant cycle.
module sp_ram_arb #(
    parameter int RAM_SIZE       = 32768,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_PORTS      = 2,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst_i,
    sp_ram_arb_if.slave   bus,
    output logic          busy_o
);
    localparam int          ADDR_WIDTH = $clog2(RAM_SIZE);
    localparam int unsigned BE_W       = DATA_WIDTH / 8;
    localparam int unsigned DEPTH      = RAM_SIZE / BE_W;
    localparam int          OFF        = $clog2(BE_W);
    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned NP         = NUM_PORTS;

    typedef enum logic {S_CLEAR, S_RUN} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;
    logic [PORT_W-1:0]     prio_q, prio_d;
    logic                  busy_q, busy_d;
    logic [NUM_PORTS-1:0]  rv1_q, rv1_d;
    logic [NUM_PORTS-1:0]  rv2_q, rv2_d;
    logic [DATA_WIDTH-1:0] rdata_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rdata_d [NUM_PORTS];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd1_q;

    logic [NUM_PORTS-1:0]  gnt;
    logic [PORT_W-1:0]     gnt_idx;
    logic                  found;
    int unsigned           cand;

    logic                  sel_we;
    logic [IDX_W-1:0]      sel_idx;
    logic [BE_W-1:0]       sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [BE_W-1:0]       mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_en;

    // Round-robin search starting at prio_q; nothing is granted while
    // clearing or while reset is asserted.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        if (!rst_i && state_q == S_RUN) begin
            for (int unsigned i = 0; i < NP; i++) begin
                cand = int'(prio_q) + i;
                if (cand >= NP) cand = cand - NP;
                if (!found && bus.req_i[cand]) begin
                    found      = 1'b1;
                    gnt[cand]  = 1'b1;
                    gnt_idx    = PORT_W'(cand);
                end
            end
        end
    end

    always_comb begin
        sel_we    = bus.we_i[gnt_idx];
        sel_idx   = bus.addr_i[int'(gnt_idx)*ADDR_WIDTH + OFF +: IDX_W];
        sel_be    = bus.be_i[int'(gnt_idx)*BE_W +: BE_W];
        sel_wdata = bus.wdata_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Single array port: the clear sequence and the granted access never
    // coincide because grants are suppressed during CLEAR.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = sel_idx;
        mem_be    = sel_be;
        mem_wdata = sel_wdata;
        rd_en     = 1'b0;
        if (!rst_i) begin
            if (state_q == S_CLEAR) begin
                mem_we    = 1'b1;
                mem_widx  = clr_cnt_q;
                mem_be    = '1;
                mem_wdata = '0;
            end else if (found) begin
                mem_we = sel_we;
                rd_en  = !sel_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (mem_be[b]) mem_q[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
        if (rd_en) rd1_q <= mem_q[sel_idx];
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        prio_d    = prio_q;
        rv1_d     = gnt & {NUM_PORTS{rd_en}};
        rv2_d     = rv1_q;
        rdata_d   = rdata_q;
        // The holding register captures each response as it leaves the
        // array register, so it serves as both the OUT_REG stage and the
        // last-value hold.
        for (int unsigned p = 0; p < NP; p++) begin
            if (rv1_q[p]) rdata_d[p] = rd1_q;
        end
        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d   = S_RUN;
                clr_cnt_d = '0;
            end
        end
        if (found) begin
            prio_d = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
        end
        busy_d = (state_d == S_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            clr_cnt_q <= '0;
            prio_q    <= '0;
            busy_q    <= (CLEAR_ON_RESET != 0);
            rv1_q     <= '0;
            rv2_q     <= '0;
            for (int unsigned p = 0; p < NP; p++) rdata_q[p] <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            prio_q    <= prio_d;
            busy_q    <= busy_d;
            rv1_q     <= rv1_d;
            rv2_q     <= rv2_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        bus.gnt_o    = gnt;
        bus.rvalid_o = (OUT_REG != 0) ? rv2_q : rv1_q;
        bus.rdata_o  = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            if (OUT_REG == 0 && rv1_q[p]) bus.rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rd1_q;
            else                          bus.rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
        end
        busy_o = busy_q;
    end
endmodule

// File: tb/tb_sp_ram_arb.sv
// tb_sp_ram_arb: randomized and directed traffic against sp_ram_arb with a
// behavioural memory/arbiter model; read responses go through a per-port
// scoreboard checked by an independent monitor.
module tb_sp_ram_arb;
    localparam int NP    = 2;
    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 8192;
    localparam int OREG  = 1;
    localparam int LAT   = 1 + OREG;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic busy_o;

    always #5 clk = ~clk;

    sp_ram_arb_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sp_ram_arb #(
        .RAM_SIZE(32768), .DATA_WIDTH(DW), .NUM_PORTS(NP),
        .OUT_REG(OREG), .CLEAR_ON_RESET(1)
    ) u_dut (
        .clk(clk), .rst_i(rst_i), .bus(bus), .busy_o(busy_o)
    );

    typedef struct {
        bit          we;
        bit [AW-1:0] addr;
        bit [BW-1:0] be;
        bit [DW-1:0] data;
        int          gap;
    } txn_t;

    typedef struct {
        bit [DW-1:0] data;
        int          due;
    } exp_t;

    txn_t        stim_q [NP][$];
    exp_t        exp_q  [NP][$];
    bit [DW-1:0] mdl    [DEPTH];
    bit          have_pend [NP];
    txn_t        pend      [NP];
    bit [DW-1:0] last_rd   [NP];
    int          clear_left = 0;
    int          prio = 0;
    int          cyc = 0;
    int          n_gnt = 0;
    int          busy_run = 0;
    bit          started = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push_rd(input int p, input int addr, input int gap);
        txn_t t;
        t.we = 0; t.addr = AW'(addr); t.be = BW'($urandom); t.data = $urandom; t.gap = gap;
        stim_q[p].push_back(t);
    endtask

    task automatic push_wr(input int p, input int addr, input int be, input bit [DW-1:0] d, input int gap);
        txn_t t;
        t.we = 1; t.addr = AW'(addr); t.be = BW'(be); t.data = d; t.gap = gap;
        stim_q[p].push_back(t);
    endtask

    function automatic int outstanding();
        int n = 0;
        for (int p = 0; p < NP; p++) n += stim_q[p].size() + exp_q[p].size() + int'(have_pend[p]);
        return n;
    endfunction

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && outstanding() != 0; i++) @(negedge clk);
        chk("drain", outstanding(), 0);
    endtask

    task automatic wait_busy_low(input int limit);
        for (int i = 0; i < limit && busy_o === 1'b1; i++) @(negedge clk);
        chk("busy_timeout", busy_o, 0);
    endtask

    // Driver and reference model: issues requests, predicts the grant from
    // the round-robin rule and applies the granted access to the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (!have_pend[p] && stim_q[p].size() > 0) begin
                    if (stim_q[p][0].gap > 0) stim_q[p][0].gap--;
                    else begin
                        pend[p] = stim_q[p].pop_front();
                        have_pend[p] = 1;
                    end
                end
                bus.req_i[p] = have_pend[p];
                if (have_pend[p]) begin
                    bus.we_i[p]                  = pend[p].we;
                    bus.addr_i[p*AW +: AW]       = pend[p].addr;
                    bus.be_i[p*BW +: BW]         = pend[p].be;
                    bus.wdata_i[p*DW +: DW]      = pend[p].data;
                end else begin
                    bus.we_i[p]                  = 1'($urandom);
                    bus.addr_i[p*AW +: AW]       = AW'($urandom);
                    bus.be_i[p*BW +: BW]         = BW'($urandom);
                    bus.wdata_i[p*DW +: DW]      = $urandom;
                end
            end
            #1;
            if (started) begin
                logic [NP-1:0] exp_g;
                int gp;
                chk("busy", busy_o, clear_left > 0);
                if (busy_o === 1'b1) busy_run++;
                else if (busy_run > 0) begin
                    chk("busy_len", busy_run, DEPTH);
                    busy_run = 0;
                end
                exp_g = '0;
                gp = -1;
                if (!rst_i && clear_left == 0) begin
                    for (int i = 0; i < NP; i++) begin
                        int p;
                        p = (prio + i) % NP;
                        if (gp < 0 && have_pend[p]) gp = p;
                    end
                end
                if (gp >= 0) exp_g[gp] = 1'b1;
                chk("gnt", bus.gnt_o, exp_g);
                if (gp >= 0) begin
                    int w;
                    prio = (gp + 1) % NP;
                    n_gnt++;
                    w = int'(pend[gp].addr[AW-1:2]);
                    if (pend[gp].we) begin
                        for (int b = 0; b < BW; b++)
                            if (pend[gp].be[b]) mdl[w][b*8 +: 8] = pend[gp].data[b*8 +: 8];
                    end else begin
                        exp_t e;
                        e.data = mdl[w];
                        e.due  = cyc + LAT;
                        exp_q[gp].push_back(e);
                    end
                    have_pend[gp] = 0;
                end
            end
            @(posedge clk);
            if (rst_i) begin
                started    = 1;
                clear_left = DEPTH;
                prio       = 0;
                busy_run   = 0;
                for (int p = 0; p < NP; p++) begin
                    while (exp_q[p].size() > 0 && exp_q[p][$].due > cyc) void'(exp_q[p].pop_back());
                    last_rd[p] = '0;
                end
                for (int w = 0; w < DEPTH; w++) mdl[w] = '0;
            end else if (clear_left > 0) begin
                clear_left--;
            end
            cyc++;
        end
    end

    // Monitor: every response must match the oldest outstanding read of that
    // port in data and cycle; between responses rdata must hold.
    always @(negedge clk) begin
        if (started) begin
            for (int p = 0; p < NP; p++) begin
                if (bus.rvalid_o[p] === 1'b1) begin
                    if (exp_q[p].size() == 0) begin
                        chk("rvalid_spurious", bus.rvalid_o[p], 0);
                    end else begin
                        exp_t e;
                        e = exp_q[p].pop_front();
                        chk("rdata", bus.rdata_o[p*DW +: DW], e.data);
                        chk("rlatency", cyc, e.due);
                        last_rd[p] = e.data;
                    end
                end else begin
                    chk("rvalid", bus.rvalid_o[p], 0);
                    chk("rhold", bus.rdata_o[p*DW +: DW], last_rd[p]);
                end
            end
        end
    end

    initial begin
        bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.be_i = '0; bus.wdata_i = '0;
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        #2;
        chk("rst_gnt", bus.gnt_o, 0);
        chk("rst_rvalid", bus.rvalid_o, 0);
        chk("rst_rdata", bus.rdata_o, 0);
        chk("rst_busy", busy_o, 1);

        // Both ports wait through the clear, then contend continuously.
        for (int k = 0; k < 4; k++) begin
            push_rd(0, 100*4 + k, 0);
            push_rd(1, (100 + k)*4, 0);
        end
        repeat (500) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        wait_busy_low(DEPTH + 50);
        wait_drain(200);

        // Partial byte-enable overwrite.
        push_wr(0, 'h40, 'hF, 32'hDEADBEEF, 0);
        push_wr(0, 'h40, 'h1, 32'h000000AA, 0);
        push_rd(0, 'h40, 0);
        wait_drain(100);

        // Read the cycle after a write to the same word, from the other port.
        push_wr(0, 'h80, 'hF, 32'h12345678, 0);
        push_rd(1, 'h82, 1);
        wait_drain(100);

        // Single requester, back-to-back reads.
        for (int k = 0; k < 8; k++) push_rd(0, 'h40 + (k % 2)*'h40, 0);
        wait_drain(100);

        // Random mixed traffic over a small address window.
        for (int k = 0; k < 150; k++) begin
            for (int p = 0; p < NP; p++) begin
                int w;
                int a;
                w = ($urandom_range(0, 4) == 0) ? 100 : int'($urandom_range(0, 15));
                a = w*4 + int'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) push_wr(p, a, int'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 2)));
                else                           push_rd(p, a, int'($urandom_range(0, 2)));
            end
        end
        wait_drain(3000);

        // Reset with reads in flight flushes their responses.
        begin
            int base;
            base = n_gnt;
            for (int k = 1; k <= 3; k++) push_rd(0, k*4, 0);
            for (int i = 0; i < 50 && n_gnt < base + 3; i++) begin
                @(negedge clk);
                #2;
            end
        end
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("flush_rvalid", bus.rvalid_o, 0);
            @(negedge clk);
        end
        wait_busy_low(DEPTH + 50);
        push_rd(1, 2*4, 0);
        push_rd(0, 100*4, 0);
        wait_drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
